pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter EXC_VECTOR, default 32'h8000_0180, PC value loaded on exception redirect.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  downstream not ready; holds issued instruction.
REQ-006 jump  input  1  unconditional redirect request.
REQ-007 jump_target  input  32  jump destination address.
REQ-008 branch_taken  input  1  taken-branch redirect request.
REQ-009 branch_target  input  32  branch destination address.
REQ-010 imem_req  output  1  instruction fetch request.
REQ-011 imem_addr  output  32  fetch address; equals current PC.
REQ-012 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-013 imem_rdata  input  32  fetched instruction word.
REQ-014 instr_valid  output  1  instr/instr_pc hold a valid instruction.
REQ-015 instr  output  32  issued instruction word.
REQ-016 instr_pc  output  32  address of issued instruction.
REQ-017 exc_req  input  1  exception redirect request (EXCEPTION_EN only).
REQ-018 epc  output  32  exception PC (EXCEPTION_EN only).

Function
REQ-019 States: BOOT, FETCH, ISSUE; encoding free; no other reachable states.
REQ-020 BOOT: imem_req=0, instr_valid=0; unconditionally -> FETCH next cycle.
REQ-021 FETCH: imem_req=1, imem_addr=pc, instr_valid=0; no ack -> stay, imem_addr held stable.
REQ-022 FETCH with imem_ack=1: instr<=imem_rdata, instr_pc<=pc, -> ISSUE; ack in same cycle as req allowed.
REQ-023 imem_ack outside FETCH is ignored.
REQ-024 ISSUE: instr_valid=1, imem_req=0; stall=1 -> stay, instr/instr_pc/pc unchanged.
REQ-025 ISSUE with stall=0: instruction consumed; pc updated by priority exc_req > jump > branch_taken > pc+4; -> FETCH.
REQ-026 Redirect inputs sampled only in ISSUE with stall=0; ignored in BOOT, FETCH, or while stalled.
REQ-027 jump and branch_taken both high: jump_target wins.
REQ-028 Target addresses: bits [1:0] forced to 0 before loading pc.
REQ-029 pc+4 is modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000, no flag.
REQ-030 Throughput with zero-wait memory and no stall: one instruction per 2 cycles; imem_req reasserts the cycle after consume.

Reset
REQ-031 reset=0 asynchronously forces: state=BOOT, pc=RESET_VECTOR, imem_req=0, instr_valid=0, instr=0, instr_pc=0, epc=0.
REQ-032 Reset mid-FETCH drops imem_req immediately; the outstanding fetch is abandoned and any late ack is ignored.
REQ-033 After reset release, first imem_req with imem_addr=RESET_VECTOR asserts on the 2nd rising edge.

Configuration
REQ-034 Macro PC_SEQUENCER_EXCEPTION_EN: when defined, exc_req and epc ports exist and exc_req has top priority per REQ-025.
REQ-035 On accepted exception: epc<=instr_pc, pc<=EXC_VECTOR; epc otherwise holds.
REQ-036 Macro undefined: exc_req and epc ports absent; priority is jump > branch_taken > pc+4.

Verification
REQ-037 Reset release, ack tied 1, stall 0 -> imem_addr sequence 0x0, 0x4, 0x8, 0xC; instr_valid every 2nd cycle.
REQ-038 ack delayed 3 cycles at addr 0x10 -> imem_addr stays 0x10 for 4 cycles; instr_pc=0x10 on issue.
REQ-039 stall=1 for 5 cycles in ISSUE with jump=1 pulsed mid-stall -> instr held; jump ignored; next fetch 0x(pc+4).
REQ-040 jump=1 (0x400) and branch_taken=1 (0x200) at consume -> next imem_addr=0x400; target 0x403 -> 0x400.
REQ-041 RESET_VECTOR=32'hFFFF_FFFC, no redirect -> second fetch at 32'h0000_0000.
REQ-042 EXCEPTION_EN, exc_req=1 with jump=1 at instr_pc=0x20 -> epc=0x20, next imem_addr=0x8000_0180; reset mid-fetch -> imem_req=0 same cycle.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch/issue/redirect bundle for pc_sequencer. The exc_req/epc members only exist when
// PC_SEQUENCER_EXCEPTION_EN is defined.
interface pc_sequencer_if;
  logic        stall;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef PC_SEQUENCER_EXCEPTION_EN
  logic        exc_req;
  logic [31:0] epc;

  modport master (
    input  stall, jump, jump_target, branch_taken, branch_target, imem_ack, imem_rdata, exc_req,
    output imem_req, imem_addr, instr_valid, instr, instr_pc, epc
  );
  modport slave (
    output stall, jump, jump_target, branch_taken, branch_target, imem_ack, imem_rdata, exc_req,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, epc
  );
`else
  modport master (
    input  stall, jump, jump_target, branch_taken, branch_target, imem_ack, imem_rdata,
    output imem_req, imem_addr, instr_valid, instr, instr_pc
  );
  modport slave (
    output stall, jump, jump_target, branch_taken, branch_target, imem_ack, imem_rdata,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc
  );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer: BOOT -> FETCH -> ISSUE loop with jump/branch redirects.
// Define PC_SEQUENCER_EXCEPTION_EN to add the exc_req redirect and the epc register.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
  input logic            clock,
  input logic            reset,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {StBoot, StFetch, StIssue} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        consume;
  logic        exc_take;

  // Redirects are only honoured at the moment the issued instruction is consumed.
  assign consume = (state_q == StIssue) && !bus.stall;

`ifdef PC_SEQUENCER_EXCEPTION_EN
  logic [31:0] epc_q;

  assign exc_take = bus.exc_req;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      epc_q <= '0;
    end else if (consume && exc_take) begin
      epc_q <= instr_pc_q;
    end
  end

  assign bus.epc = epc_q;
`else
  assign exc_take = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StBoot;
      pc_q       <= RESET_VECTOR;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      StBoot: state_d = StFetch;
      StFetch: begin
        if (bus.imem_ack) begin
          instr_d    = bus.imem_rdata;
          instr_pc_d = pc_q;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (consume) begin
          state_d = StFetch;
          if (exc_take) begin
            pc_d = EXC_VECTOR;
          end else if (bus.jump) begin
            pc_d = bus.jump_target & ~32'h3;
          end else if (bus.branch_taken) begin
            pc_d = bus.branch_target & ~32'h3;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      default: state_d = StBoot;
    endcase
  end

  // Outputs decode straight from state so an asynchronous reset drops them at once.
  assign bus.imem_req    = (state_q == StFetch);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == StIssue);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule
